// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, reset PC, bubble encoding, IF/ID payload.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  // add x0,x0,x0 -- architecturally a no-op, used as the IF/ID bubble
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0033;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC priority mux: branch > flush > stall > sequential.
module pc_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q, pc_d;

  // Next-PC selection; a flush still advances since the squashed slot is refetched elsewhere.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (branch_taken) begin
      pc_d = {branch_target[XLEN-1:2], 2'b00};
    end else if (flush) begin
      pc_d = pc_q + XLEN'(4);
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // PC state register, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: drives ROM word address from the PC and captures the returned word into IF/ID.
module instr_fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count
);

  logic [XLEN-1:0] pc;
  if_id_t          if_id_q, if_id_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  pc_reg u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc)
  );

  // Upper PC bits are dropped, so fetch wraps around the ROM.
  assign imem_addr = pc[IMEM_AW+1:2];

  // IF/ID and fetch counter next state, same priority order as the PC mux.
  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken || flush) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (!stall) begin
      if_id_d       = '{pc: pc, instr: imem_data, valid: 1'b1};
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // IF/ID pipeline register and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q       <= IF_ID_BUBBLE;
      fetch_count_q <= '0;
    end else begin
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_out      = pc;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a combinational ROM model (mem[i] = C0DE_0000 | i).
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out, if_id_pc, if_id_instr, fetch_count;
  logic        if_id_valid;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [64];

  instr_fetch_stage #(.IMEM_AW(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full visible state in one go.
  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                             input logic [31:0] e_instr, input logic e_valid,
                             input logic [31:0] e_cnt);
    check_eq({tag, ".pc"},    pc_out,      e_pc);
    check_eq({tag, ".addr"},  {26'd0, imem_addr}, {26'd0, e_pc[7:2]});
    check_eq({tag, ".ifpc"},  if_id_pc,    e_ipc);
    check_eq({tag, ".instr"}, if_id_instr, e_instr);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check_eq({tag, ".cnt"},   fetch_count, e_cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #12;
    check_state("rst", 32'h0, 32'h0, 32'h33, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    step(); check_state("seq0", 32'h4, 32'h0, 32'hC0DE_0000, 1'b1, 32'd1);
    step(); check_state("seq1", 32'h8, 32'h4, 32'hC0DE_0001, 1'b1, 32'd2);

    // Two stall cycles at pc=8
    stall = 1'b1;
    step(); check_state("stl0", 32'h8, 32'h4, 32'hC0DE_0001, 1'b1, 32'd2);
    step(); check_state("stl1", 32'h8, 32'h4, 32'hC0DE_0001, 1'b1, 32'd2);
    stall = 1'b0;
    step(); check_state("stlr", 32'hC, 32'h8, 32'hC0DE_0002, 1'b1, 32'd3);
    step(); check_state("seq3", 32'h10, 32'hC, 32'hC0DE_0003, 1'b1, 32'd4);

    // Branch at pc=16 to 36
    branch_taken = 1'b1; branch_target = 32'd36;
    step(); check_state("br0", 32'd36, 32'h0, 32'h33, 1'b0, 32'd4);
    branch_taken = 1'b0;
    step(); check_state("br1", 32'd40, 32'd36, 32'hC0DE_0009, 1'b1, 32'd5);

    // Branch overrides stall and flush; target low bits cleared
    branch_taken = 1'b1; stall = 1'b1; flush = 1'b1; branch_target = 32'h0000_0017;
    step(); check_state("brp0", 32'h14, 32'h0, 32'h33, 1'b0, 32'd5);
    branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
    step(); check_state("brp1", 32'h18, 32'h14, 32'hC0DE_0005, 1'b1, 32'd6);

    // Flush alone, then flush with stall: both bubble and advance
    flush = 1'b1;
    step(); check_state("fl", 32'h1C, 32'h0, 32'h33, 1'b0, 32'd6);
    stall = 1'b1;
    step(); check_state("flst", 32'h20, 32'h0, 32'h33, 1'b0, 32'd6);
    flush = 1'b0; stall = 1'b0;

    // ROM address wrap
    branch_taken = 1'b1; branch_target = 32'd252;
    step(); check_state("aw0", 32'd252, 32'h0, 32'h33, 1'b0, 32'd6);
    branch_taken = 1'b0;
    step(); check_state("aw1", 32'd256, 32'd252, 32'hC0DE_003F, 1'b1, 32'd7);

    // PC wrap at 2^32
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step(); check_state("pw0", 32'hFFFF_FFFC, 32'h0, 32'h33, 1'b0, 32'd7);
    branch_taken = 1'b0;
    step(); check_state("pw1", 32'h0, 32'hFFFF_FFFC, 32'hC0DE_003F, 1'b1, 32'd8);
    step(); check_state("pw2", 32'h4, 32'h0, 32'hC0DE_0000, 1'b1, 32'd9);

    // Async reset mid-stall, between edges
    stall = 1'b1;
    step(); check_state("ms", 32'h4, 32'h0, 32'hC0DE_0000, 1'b1, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("arst", 32'h0, 32'h0, 32'h33, 1'b0, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(); check_state("rel", 32'h4, 32'h0, 32'hC0DE_0000, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
